// File: rtl/trace_output_arbiter.sv
// Merges completed trace elements from the ID/EX/WB trackers into one stream ordered by
// if_data.time_start, with a small FIFO per source and a valid/ready sink.
package trace_output_arbiter_pkg;
  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] pc;
  } if_data_t;

  typedef struct packed {
    if_data_t    if_data;
    logic [31:0] insn;
  } trace_output;
endpackage

module trace_output_arbiter
  import trace_output_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 3,
  parameter int SLOT_DEPTH  = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic        [NUM_SOURCES-1:0]       src_valid,
  input  trace_output [NUM_SOURCES-1:0]       src_data,
  output logic                                out_valid,
  output trace_output                         out_data,
  input  logic                                out_ready,
  output logic        [NUM_SOURCES-1:0]       overflow,
  input  logic                                overflow_clr,
  output logic        [CNT_WIDTH-1:0]         emitted_count
);
  localparam int PW = $clog2(SLOT_DEPTH);
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, PRESENT} state_t;

  state_t             state, state_next;
  trace_output        mem [NUM_SOURCES][SLOT_DEPTH];
  logic [PW-1:0]      rd_ptr [NUM_SOURCES];
  logic [PW-1:0]      wr_ptr [NUM_SOURCES];
  logic [PW:0]        count [NUM_SOURCES];
  logic [PW:0]        count_next [NUM_SOURCES];
  logic [SW-1:0]      sel, winner;
  logic               found;
  logic [31:0]        best;
  logic [NUM_SOURCES-1:0] push, pop, full, nonempty, nonempty_next, drop;
  logic               fire;

  assign out_valid = (state == PRESENT);
  assign fire      = out_valid & out_ready;

  // A full FIFO still accepts a write when its head leaves in the same cycle.
  always_comb begin
    push          = '0;
    pop           = '0;
    full          = '0;
    nonempty      = '0;
    nonempty_next = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      full[i]          = (count[i] == (PW+1)'(SLOT_DEPTH));
      nonempty[i]      = (count[i] != '0);
      pop[i]           = fire && (sel == SW'(i));
      push[i]          = src_valid[i] && (!full[i] || pop[i]);
      count_next[i]    = count[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      nonempty_next[i] = (count_next[i] != '0);
    end
    drop = src_valid & ~push;
  end

  // Oldest head wins; strict compare keeps the lowest index on a tie.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    best   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (nonempty[i] && (!found || (mem[i][rd_ptr[i]].if_data.time_start < best))) begin
        winner = SW'(i);
        found  = 1'b1;
        best   = mem[i][rd_ptr[i]].if_data.time_start;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|nonempty) state_next = SELECT;
      SELECT:  state_next = PRESENT;
      PRESENT: if (fire) state_next = (|nonempty_next) ? SELECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sel           <= '0;
      out_data      <= '{default: '0};
      overflow      <= '0;
      emitted_count <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      state    <= state_next;
      overflow <= (overflow & ~{NUM_SOURCES{overflow_clr}}) | drop;
      if (fire) emitted_count <= emitted_count + CNT_WIDTH'(1);
      if (state == SELECT) begin
        sel      <= winner;
        out_data <= mem[winner][rd_ptr[winner]];
      end
      for (int i = 0; i < NUM_SOURCES; i++) begin
        count[i] <= count_next[i];
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= src_data[i];
    end
  end
endmodule

// File: tb/tb_trace_output_arbiter.sv
// Bench for trace_output_arbiter: table of simultaneous-arrival vectors plus hand-written
// sequences for latency, back-pressure, overflow, full-FIFO pass-through and async reset.
module tb_trace_output_arbiter;
  import trace_output_arbiter_pkg::*;

  localparam int NS = 3;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic        [NS-1:0]      src_valid = '0;
  trace_output [NS-1:0]      src_data = '0;
  logic                      out_valid;
  trace_output               out_data;
  logic                      out_ready = 1'b0;
  logic        [NS-1:0]      overflow;
  logic                      overflow_clr = 1'b0;
  logic        [31:0]        emitted_count;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  trace_output_arbiter #(.NUM_SOURCES(NS), .SLOT_DEPTH(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .overflow(overflow), .overflow_clr(overflow_clr), .emitted_count(emitted_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] ts [3];
    int          n;
    int          ord [3];
  } vec_t;

  vec_t vecs [5];

  function automatic logic [31:0] tag(input int s);
    return 32'hA000_0000 | 32'(s);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every handshake must match the next expected element.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got ts=%0d insn=0x%0h expected nothing",
                 out_data.if_data.time_start, out_data.insn);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_data.if_data.time_start, out_data.insn} !== e) begin
          bad++;
          $display("FAIL out_order: got ts=%0d insn=0x%0h expected ts=%0d insn=0x%0h",
                   out_data.if_data.time_start, out_data.insn, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic expect_out(input logic [31:0] ts, input int s);
    exp_q.push_back({ts, tag(s)});
  endtask

  task automatic strobe(input logic [2:0] mask, input logic [31:0] t0,
                        input logic [31:0] t1, input logic [31:0] t2);
    src_valid = mask;
    src_data[0] = '{if_data: '{time_start: t0, pc: 32'h0}, insn: tag(0)};
    src_data[1] = '{if_data: '{time_start: t1, pc: 32'h4}, insn: tag(1)};
    src_data[2] = '{if_data: '{time_start: t2, pc: 32'h8}, insn: tag(2)};
    @(posedge clk); #1;
    src_valid = '0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    if (k == 20) check(name, 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_overflow();
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    check("overflow_clr", 64'(overflow), 64'd0);
  endtask

  initial begin
    logic [31:0] base;
    logic        stable;

    vecs[0] = '{mask: 3'b111, ts: '{32'd30, 32'd20, 32'd20}, n: 3, ord: '{1, 2, 0}};
    vecs[1] = '{mask: 3'b111, ts: '{32'd7, 32'd7, 32'd7},    n: 3, ord: '{0, 1, 2}};
    vecs[2] = '{mask: 3'b101, ts: '{32'd50, 32'd0, 32'd40},  n: 2, ord: '{2, 0, 0}};
    vecs[3] = '{mask: 3'b011, ts: '{32'hFFFF_FFFF, 32'd1, 32'd0}, n: 2, ord: '{1, 0, 0}};
    vecs[4] = '{mask: 3'b010, ts: '{32'd0, 32'd9, 32'd0},    n: 1, ord: '{1, 0, 0}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data.if_data.time_start) | 64'(out_data.insn), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(emitted_count), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single element latency
    out_ready = 1'b1;
    expect_out(32'd10, 2);
    strobe(3'b100, 32'd0, 32'd0, 32'd10);
    check("lat_t0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_t1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_t2", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_data.if_data.time_start), 64'd10);
    @(posedge clk); #1;
    check("lat_idle", 64'(out_valid), 64'd0);
    check("lat_count", 64'(emitted_count), 64'd1);

    // Table-driven simultaneous arrivals
    for (int v = 0; v < 5; v++) begin
      base = emitted_count;
      for (int k = 0; k < vecs[v].n; k++)
        expect_out(vecs[v].ts[vecs[v].ord[k]], vecs[v].ord[k]);
      strobe(vecs[v].mask, vecs[v].ts[0], vecs[v].ts[1], vecs[v].ts[2]);
      drain($sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_count", v), 64'(emitted_count - base), 64'(vecs[v].n));
    end
    check("cnt_after_table", 64'(emitted_count), 64'd12);

    // Held element is not pre-empted by an older arrival
    out_ready = 1'b0;
    expect_out(32'd8, 1);
    expect_out(32'd5, 0);
    strobe(3'b010, 32'd0, 32'd8, 32'd0);
    wait_valid("hold_valid");
    strobe(3'b001, 32'd5, 32'd0, 32'd0);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!out_valid || out_data.if_data.time_start != 32'd8) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    drain("hold_drain");

    // Overflow on source 1
    out_ready = 1'b0;
    base = emitted_count;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) expect_out(32'd100 + 32'(k), 1);
      strobe(3'b010, 32'd0, 32'd100 + 32'(k), 32'd0);
    end
    @(posedge clk); #1;
    check("ovf_bits", 64'(overflow), 64'b010);
    out_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_count", 64'(emitted_count - base), 64'd4);
    check("ovf_sticky", 64'(overflow), 64'b010);
    clear_overflow();

    // Full FIFO accepts a write in the cycle its head is popped
    out_ready = 1'b0;
    base = emitted_count;
    for (int k = 0; k < 5; k++) expect_out(32'd200 + 32'(k), 0);
    for (int k = 0; k < 4; k++) strobe(3'b001, 32'd200 + 32'(k), 32'd0, 32'd0);
    wait_valid("full_valid");
    out_ready = 1'b1;
    strobe(3'b001, 32'd204, 32'd0, 32'd0);
    out_ready = 1'b0;
    check("full_no_ovf", 64'(overflow), 64'd0);
    wait_valid("full_valid2");
    strobe(3'b001, 32'd205, 32'd0, 32'd0);
    check("full_occ4", 64'(overflow), 64'b001);
    out_ready = 1'b1;
    drain("full_drain");
    check("full_count", 64'(emitted_count - base), 64'd5);
    clear_overflow();

    // Asynchronous reset mid-PRESENT
    out_ready = 1'b0;
    strobe(3'b111, 32'd300, 32'd301, 32'd302);
    wait_valid("arst_valid");
    #3 rst = 1'b0;
    #1;
    check("arst_valid_low", 64'(out_valid), 64'd0);
    check("arst_count", 64'(emitted_count), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("arst_no_stale", 64'(stable), 64'd1);
    check("arst_count_after", 64'(emitted_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
